syscall_print_engine: RTL and testbench

Sequential service unit answering the syscall requests raised in the ID stage of the pipelined MIPS core. It decodes the service code (`$v0`) and argument (`$a0`) and reads NUL-terminated strings from data memory one word at a time. It converts signed integers to decimal ASCII and streams the resulting characters to a console sink over a valid/ready handshake. While it works it holds the pipeline stalled. It also raises the exit signal that stops the clock and triggers the statistics dump.

---
 rtl/syscall_pkg.sv | 39 +++
 rtl/syscall_print_engine_dec_digit_unit.sv | 40 ++++
 rtl/syscall_print_engine.sv | 177 +++++++++++++++++
 tb/tb_syscall_print_engine.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/syscall_pkg.sv
// Shared constants for the syscall print engine: service codes, FSM states,
// ASCII helpers and the powers-of-ten ROM used by integer printing.
package syscall_pkg;

  localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
  localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
  localparam logic [31:0] SYS_EXIT       = 32'd10;
  localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_RD_REQ    = 4'd2;
  localparam logic [3:0] S_RD_WAIT   = 4'd3;
  localparam logic [3:0] S_STR_EMIT  = 4'd4;
  localparam logic [3:0] S_INT_SIGN  = 4'd5;
  localparam logic [3:0] S_INT_DIGIT = 4'd6;
  localparam logic [3:0] S_CHAR_EMIT = 4'd7;
  localparam logic [3:0] S_DONE      = 4'd8;

  localparam logic [7:0] ASCII_MINUS = 8'h2d;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  // Entry i holds 10^i.
  localparam logic [9:0][31:0] POW10 = {
    32'd1000000000, 32'd100000000, 32'd10000000, 32'd1000000, 32'd100000,
    32'd10000,      32'd1000,      32'd100,      32'd10,       32'd1
  };

  // Big-endian byte lane: offset 0 is the most significant byte.
  function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] off);
    case (off)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

endpackage

// File: rtl/syscall_print_engine_dec_digit_unit.sv
// One decimal digit by repeated subtraction: digit = mag / pow, rem = mag % pow,
// valid while done pulses. Callers guarantee mag < 10*pow, so at most 9 subtracts.
module dec_digit_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] mag,
  input  logic [31:0] pow,
  output logic [3:0]  digit,
  output logic [31:0] rem,
  output logic        done
);

  logic busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      digit <= 4'd0;
      rem   <= 32'd0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy  <= 1'b1;
        digit <= 4'd0;
        rem   <= mag;
      end else if (busy) begin
        if (rem >= pow) begin
          rem   <= rem - pow;
          digit <= digit + 4'd1;
        end else begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/syscall_print_engine.sv
// Syscall service unit: decodes $v0/$a0, streams print_int/print_string/print_char
// output to a console sink and stalls IF/ID until the service completes.
module syscall_print_engine
  import syscall_pkg::*;
#(
  parameter int MAX_LEN = 4096,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [31:0]       req_code,
  input  logic [31:0]       req_arg,
  output logic              sysstall,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              char_valid,
  output logic [7:0]        char_data,
  input  logic              char_ready,
  output logic              exit_o,
  output logic              err
);

  logic [3:0]        state;
  logic [31:0]       code_q, arg_q, word_q, mag_q, count_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [3:0]        pow_idx;
  logic              started_q, dg_run, done_q;

  logic [3:0]  dg_digit;
  logic [31:0] dg_rem;
  logic        dg_done, dg_start;

  logic        hs, emit_digit;
  logic [1:0]  off_nx;
  logic [7:0]  rd_byte, nx_byte;
  logic [31:0] count_nx;

  assign sysstall   = (req_valid & ~done_q) | (state != S_IDLE);
  assign mem_rd     = (state == S_RD_REQ);
  assign mem_addr   = {ptr_q[ADDR_W-1:2], 2'b00};
  assign hs         = char_valid & char_ready;
  assign off_nx     = ptr_q[1:0] + 2'd1;
  assign rd_byte    = be_byte(mem_rdata, ptr_q[1:0]);
  assign nx_byte    = be_byte(word_q, off_nx);
  assign count_nx   = count_q + 32'd1;
  assign dg_start   = (state == S_INT_DIGIT) && !dg_run && !char_valid;
  assign emit_digit = (dg_digit != 4'd0) || started_q || (pow_idx == 4'd0);

  dec_digit_unit u_dec (
    .clk   (clk),
    .rst_n (rst_n),
    .start (dg_start),
    .mag   (mag_q),
    .pow   (POW10[pow_idx]),
    .digit (dg_digit),
    .rem   (dg_rem),
    .done  (dg_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      code_q     <= '0;
      arg_q      <= '0;
      word_q     <= '0;
      mag_q      <= '0;
      count_q    <= '0;
      ptr_q      <= '0;
      pow_idx    <= '0;
      started_q  <= 1'b0;
      dg_run     <= 1'b0;
      done_q     <= 1'b0;
      char_valid <= 1'b0;
      char_data  <= '0;
      exit_o     <= 1'b0;
      err        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        // done_q blocks re-accepting the syscall still sitting in ID.
        S_IDLE: if (req_valid && !done_q) begin
          code_q  <= req_code;
          arg_q   <= req_arg;
          ptr_q   <= req_arg[ADDR_W-1:0];
          count_q <= '0;
          state   <= S_DECODE;
        end
        S_DECODE: case (code_q)
          SYS_PRINT_STR:  state <= S_RD_REQ;
          SYS_PRINT_INT:  state <= S_INT_SIGN;
          SYS_PRINT_CHAR: begin
            char_valid <= 1'b1;
            char_data  <= arg_q[7:0];
            state      <= S_CHAR_EMIT;
          end
          SYS_EXIT: begin
            exit_o <= 1'b1;
            state  <= S_DONE;
          end
          default: begin
            err   <= 1'b1;
            state <= S_DONE;
          end
        endcase
        S_RD_REQ: state <= S_RD_WAIT;
        S_RD_WAIT: begin
          word_q <= mem_rdata;
          if (rd_byte == 8'h00) state <= S_DONE;
          else if (count_q >= 32'(MAX_LEN)) begin
            err   <= 1'b1;
            state <= S_DONE;
          end else begin
            char_valid <= 1'b1;
            char_data  <= rd_byte;
            state      <= S_STR_EMIT;
          end
        end
        // Next byte comes from the latched word unless the pointer crosses a word.
        S_STR_EMIT: if (hs) begin
          ptr_q      <= ptr_q + ADDR_W'(1);
          count_q    <= count_nx;
          char_valid <= 1'b0;
          if (ptr_q[1:0] == 2'd3) state <= S_RD_REQ;
          else if (nx_byte == 8'h00) state <= S_DONE;
          else if (count_nx >= 32'(MAX_LEN)) begin
            err   <= 1'b1;
            state <= S_DONE;
          end else begin
            char_valid <= 1'b1;
            char_data  <= nx_byte;
          end
        end
        // Two's-complement negate also handles 0x80000000 as unsigned 2^31.
        S_INT_SIGN: if (!char_valid) begin
          mag_q     <= arg_q[31] ? (~arg_q + 32'd1) : arg_q;
          pow_idx   <= 4'd9;
          started_q <= 1'b0;
          if (arg_q[31]) begin
            char_valid <= 1'b1;
            char_data  <= ASCII_MINUS;
          end else state <= S_INT_DIGIT;
        end else if (char_ready) begin
          char_valid <= 1'b0;
          state      <= S_INT_DIGIT;
        end
        S_INT_DIGIT: begin
          if (dg_start) dg_run <= 1'b1;
          else if (dg_run && dg_done) begin
            dg_run <= 1'b0;
            mag_q  <= dg_rem;
            if (emit_digit) begin
              char_valid <= 1'b1;
              char_data  <= ASCII_ZERO + {4'd0, dg_digit};
              started_q  <= 1'b1;
            end else pow_idx <= pow_idx - 4'd1;
          end else if (hs) begin
            char_valid <= 1'b0;
            if (pow_idx == 4'd0) state <= S_DONE;
            else pow_idx <= pow_idx - 4'd1;
          end
        end
        S_CHAR_EMIT: if (hs) begin
          char_valid <= 1'b0;
          state      <= S_DONE;
        end
        S_DONE: begin
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_syscall_print_engine.sv
// Directed + randomized bench for syscall_print_engine against a string-level model.
module tb_syscall_print_engine;
  localparam int MAX_LEN = 16;

  logic        clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, char_ready = 1'b1;
  logic [31:0] req_code = '0, req_arg = '0, mem_rdata = '0;
  logic        sysstall, mem_rd, char_valid, exit_o, err;
  logic [31:0] mem_addr;
  logic [7:0]  char_data;

  int checks = 0, errors = 0;
  int stab_chk = 0, stab_err = 0;
  logic [31:0] mem [0:255];
  logic [31:0] rd_q[$];
  logic [7:0]  out_q[$];
  bit bp_en = 0, exp_exit = 0, exp_err = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_d = '0;

  syscall_print_engine #(.MAX_LEN(MAX_LEN), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_code(req_code),
    .req_arg(req_arg), .sysstall(sysstall), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .exit_o(exit_o), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) char_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;

  always @(posedge clk) begin
    if (mem_rd) begin
      mem_rdata <= mem[mem_addr[9:2]];
      rd_q.push_back(mem_addr);
    end
  end

  // Sink: capture transfers and watch that a stalled character stays put.
  always @(posedge clk) begin
    if (!rst_n) prev_stall <= 1'b0;
    else begin
      if (prev_stall) begin
        stab_chk <= stab_chk + 1;
        if (!(char_valid === 1'b1 && char_data === prev_d)) stab_err <= stab_err + 1;
      end
      if (char_valid && char_ready) out_q.push_back(char_data);
      prev_stall <= char_valid && !char_ready;
      prev_d     <= char_data;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_str(input string tag, input string got, input string exp);
    checks++;
    assert (got == exp) else begin
      errors++;
      $error("FAIL %s: got \"%s\" expected \"%s\"", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mbyte(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]] >> ((3 - int'(a[1:0])) * 8);
    return w[7:0];
  endfunction

  task automatic set_byte(input logic [31:0] a, input logic [7:0] v);
    mem[a[9:2]][(3 - int'(a[1:0])) * 8 +: 8] = v;
  endtask

  // Expected console text and error flag for one syscall.
  task automatic model(input logic [31:0] code, input logic [31:0] arg,
                       output string exp, output bit e_err);
    logic [31:0] a;
    int n;
    exp = "";
    e_err = 0;
    case (code)
      32'd1: exp = $sformatf("%0d", $signed(arg));
      32'd4: begin
        a = arg;
        n = 0;
        while (mbyte(a) != 8'h00) begin
          if (n == MAX_LEN) begin e_err = 1; break; end
          exp = $sformatf("%s%c", exp, mbyte(a));
          a++;
          n++;
        end
      end
      32'd10: ;
      32'd11: exp = $sformatf("%c", arg[7:0]);
      default: e_err = 1;
    endcase
  endtask

  // Issue one syscall from a negedge, hold it until sysstall drops, then compare.
  task automatic run(input string tag, input logic [31:0] code, input logic [31:0] arg,
                     input bit bp, output int lat);
    string exp, got;
    bit e_err, fin;
    out_q.delete();
    rd_q.delete();
    model(code, arg, exp, e_err);
    exp_err  = exp_err | e_err;
    if (code == 32'd10) exp_exit = 1;
    bp_en     = bp;
    req_code  = code;
    req_arg   = arg;
    req_valid = 1'b1;
    lat = -1;
    fin = 0;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      if (char_valid && lat < 0) lat = c;
      if (!sysstall) begin fin = 1; break; end
    end
    req_valid = 1'b0;
    bp_en     = 0;
    check({tag, "_complete"}, fin, 1);
    @(negedge clk);
    check({tag, "_idle"}, sysstall, 0);
    got = "";
    foreach (out_q[i]) got = $sformatf("%s%c", got, out_q[i]);
    check_str({tag, "_text"}, got, exp);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_exit"}, exit_o, exp_exit);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    exp_exit = 0;
    exp_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int lat;
    logic [31:0] a, v;
    int len;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'h48692100;               // "Hi!\0" at 0x100
    mem[8'h60] = 32'h48656c6c;               // "Hello" at 0x180
    mem[8'h61] = 32'h6f000000;
    for (int i = 0; i < 4; i++) mem[8'hC0 + i] = 32'h61616161;  // 16 chars at 0x300
    for (int i = 0; i < 5; i++) mem[8'hD0 + i] = 32'h7a7a7a7a;  // 20 chars at 0x340

    repeat (2) @(negedge clk);
    check("rst_sysstall", sysstall, 0);
    check("rst_char_valid", char_valid, 0);
    check("rst_char_data", char_data, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_exit", exit_o, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run("char_A", 32'd11, 32'h41, 0, lat);
    check("char_lat", lat, 2);

    run("str_bang", 32'd4, 32'h102, 0, lat);
    check("str_lat", lat, 4);
    check("str_bang_nrd", rd_q.size(), 1);
    if (rd_q.size() > 0) check("str_bang_addr", rd_q[0], 32'h100);

    mem[8'h40] = 32'h41424344;
    mem[8'h41] = 32'h45460000;
    run("str_cross", 32'd4, 32'h103, 0, lat);
    check("str_cross_nrd", rd_q.size(), 2);
    if (rd_q.size() == 2) begin
      check("str_cross_rd0", rd_q[0], 32'h100);
      check("str_cross_rd1", rd_q[1], 32'h104);
    end

    run("int_0", 32'd1, 32'd0, 0, lat);
    run("int_m7", 32'd1, 32'hFFFFFFF9, 0, lat);
    run("int_min", 32'd1, 32'h80000000, 0, lat);
    run("int_1e9", 32'd1, 32'd1000000000, 0, lat);
    for (int k = 0; k < 8; k++) run("int_rand", 32'd1, $urandom, k[0], lat);

    run("hello_bp", 32'd4, 32'h180, 1, lat);

    for (int k = 0; k < 6; k++) begin
      for (int i = 8'h80; i < 8'h88; i++) mem[i] = 32'h0;
      a = 32'h200 + 32'($urandom_range(0, 3));
      len = $urandom_range(0, 12);
      for (int j = 0; j < len; j++) begin
        v = 32'($urandom_range(33, 126));
        set_byte(a + 32'(j), v[7:0]);
      end
      run("str_rand", 32'd4, a, 1, lat);
    end

    run("str_maxlen", 32'd4, 32'h300, 0, lat);

    // Reset in the middle of a backpressured string.
    out_q.delete();
    bp_en = 1;
    req_code = 32'd4;
    req_arg = 32'h180;
    req_valid = 1'b1;
    repeat (7) @(negedge clk);
    req_valid = 1'b0;
    #1 rst_n = 1'b0;
    exp_exit = 0;
    exp_err = 0;
    #1;
    check("midrst_char_valid", char_valid, 0);
    check("midrst_char_data", char_data, 0);
    check("midrst_mem_rd", mem_rd, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_sysstall", sysstall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bp_en = 0;
    @(negedge clk);
    check("midrst_idle", sysstall, 0);
    run("char_post_rst", 32'd11, 32'h7a, 0, lat);
    check("char_post_rst_lat", lat, 2);

    run("exit", 32'd10, 32'd0, 0, lat);
    run("exit_again", 32'd10, 32'd0, 0, lat);
    run("str_overflow", 32'd4, 32'h340, 0, lat);

    pulse_reset();
    check("rst2_exit", exit_o, 0);
    run("bad_code", 32'd99, 32'd0, 0, lat);

    check("hold_stable_violations", stab_err, 0);
    check("hold_stable_seen", stab_chk > 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
